freq_div_multi: RTL

FREQ_DIV_MULTI -- requirements
Module: freq_div_multi

---
 rtl/freq_div_pkg.sv | 8 +
 rtl/freq_div_ch.sv | 103 ++++++++++
 rtl/freq_div_multi.sv | 38 +++
 3 files changed

// File: rtl/freq_div_pkg.sv
// Shared constants for the multi-channel clock divider.
package freq_div_pkg;

  localparam int unsigned DivWDefault   = 16;
  localparam int unsigned DefDivDefault = 2;
  localparam int unsigned MinDiv        = 2;

endpackage

// File: rtl/freq_div_ch.sv
// One divider channel: a ceil(N/2)-high square wave with a rising-edge tick and a
// divisor that can be reloaded at period boundaries.
module freq_div_ch
  import freq_div_pkg::*;
#(
  parameter int unsigned DIV_W   = DivWDefault,
  parameter int unsigned DEF_DIV = DefDivDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] val_i,
  output logic             out_o,
  output logic             tick_o,
  output logic             err_o,
  output logic [DIV_W-1:0] active_o
);

  localparam logic [DIV_W-1:0] DefDiv  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MinDivW = DIV_W'(MinDiv);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             run_q;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             load_ok, wrap;
  logic [DIV_W-1:0] high_len;

  always_comb begin
    load_ok    = load_i && (val_i >= MinDivW);
    wrap       = run_q && (cnt_q == act_q - DIV_W'(1));
    cnt_d      = '0;
    out_d      = 1'b0;
    tick_d     = 1'b0;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = load_i && !load_ok;
    high_len   = '0;
    if (!en_i) begin
      // Idle channel: counter parked at 0, new divisors apply at once.
      if (load_ok) begin
        act_d      = val_i;
        pend_d     = val_i;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end else begin
      if (!run_q || wrap) begin
        cnt_d = '0;
        if (pend_vld_q) begin
          act_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      // A load seen on a boundary edge only waits for the following boundary.
      if (load_ok) begin
        pend_d     = val_i;
        pend_vld_d = 1'b1;
      end
      high_len = (act_d >> 1) + DIV_W'(act_d[0]);
      out_d    = (cnt_d < high_len);
      tick_d   = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      act_q      <= DefDiv;
      pend_q     <= DefDiv;
      pend_vld_q <= 1'b0;
      run_q      <= 1'b0;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      run_q      <= en_i;
      out_q      <= out_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign out_o    = out_q;
  assign tick_o   = tick_q;
  assign err_o    = err_q;
  assign active_o = act_q;

endmodule

// File: rtl/freq_div_multi.sv
// Array of independent clock-divider channels; this level only packs and unpacks
// the per-channel buses.
module freq_div_multi
  import freq_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = DivWDefault,
  parameter int unsigned DEF_DIV = DefDivDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [NUM_CH-1:0]       div_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       load_err,
  output logic [NUM_CH*DIV_W-1:0] div_active
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    freq_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (en[i]),
      .load_i   (div_load[i]),
      .val_i    (div_val[i*DIV_W +: DIV_W]),
      .out_o    (div_out[i]),
      .tick_o   (tick[i]),
      .err_o    (load_err[i]),
      .active_o (div_active[i*DIV_W +: DIV_W])
    );
  end

endmodule
